// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port (WE3/A3/WD3) between
// NREQ writeback requesters using valid/ready handshakes.
// Arbitration is round-robin. With PRIO0=1, requester 0 has fixed top priority,
// and a starvation guard blocks it for one cycle once another requester has
// waited MAX_WAIT cycles.
// The write-port outputs are registered. rd==0 requests are accepted but do not
// raise wb_we.
// Optional feature, enabled by defining WB_BYPASS_EN: an issue-stage bypass
// compare against the pending write (ports byp_ra1/byp_ra2/byp_hit1/byp_hit2/byp_data).
module regfile_wb_arbiter #(
  parameter int NREQ     = 3,
  parameter int PRIO0    = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wb_we,
  output logic [4:0]           wb_addr,
  output logic [31:0]          wb_data,
`ifdef WB_BYPASS_EN
  input  logic [4:0]           byp_ra1,
  input  logic [4:0]           byp_ra2,
  output logic                 byp_hit1,
  output logic                 byp_hit2,
  output logic [31:0]          byp_data,
`endif
  output logic                 pipe_stall
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST     = PW'(NREQ - 1);
  localparam logic [PW-1:0] PTR_RST  = (PRIO0 != 0) ? PW'(1) : '0;
  localparam logic [7:0]    WAIT_LIM = 8'(MAX_WAIT);

  logic [PW-1:0]   ptr;
  int unsigned     ptr_u;
  logic [7:0]      wait_cnt [1:NREQ-1];
  logic            guard;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   cand;
  logic            found;
  logic            xfer;
  logic [4:0]      sel_rd;
  logic [31:0]     sel_data;

  assign ptr_u = 32'(ptr);

  // A guard cycle exists when any non-0 requester has waited long enough.
  always_comb begin
    guard = 1'b0;
    if (PRIO0 != 0) begin
      for (int unsigned i = 1; i < NREQ; i++) begin
        if (wait_cnt[i] >= WAIT_LIM) guard = 1'b1;
      end
    end
  end

  // Pick the winner: requester 0 first (PRIO0, no guard), then scan round-robin from ptr.
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    if (PRIO0 != 0) begin
      if (req_valid[0] && !guard) begin
        grant[0] = 1'b1;
        found    = 1'b1;
      end else begin
        // ptr lives in 1..NREQ-1 here, so the scan wraps within that range.
        for (int unsigned k = 0; k < NREQ - 1; k++) begin
          cand = PW'(1 + ((ptr_u - 1 + k) % (NREQ - 1)));
          if (!found && req_valid[cand]) begin
            grant[cand] = 1'b1;
            gidx        = cand;
            found       = 1'b1;
          end
        end
      end
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand = PW'((ptr_u + k) % NREQ);
        if (!found && req_valid[cand]) begin
          grant[cand] = 1'b1;
          gidx        = cand;
          found       = 1'b1;
        end
      end
    end
  end

  assign req_ready  = rst ? grant : '0;
  assign xfer       = |req_ready;
  assign pipe_stall = req_valid[0] & ~req_ready[0];

  // Route the accepted requester's payload to the output register.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_rd   = req_rd[5*i +: 5];
        sel_data = req_data[32*i +: 32];
      end
    end
  end

  // The round-robin pointer moves past the accepted requester; requester 0 never moves it under PRIO0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= PTR_RST;
    end else if (xfer) begin
      if (PRIO0 == 0) begin
        ptr <= (gidx == LAST) ? '0 : gidx + PW'(1);
      end else if (gidx != '0) begin
        ptr <= (gidx == LAST) ? PW'(1) : gidx + PW'(1);
      end
    end
  end

  // Per-requester wait counters: count blocked cycles, saturate, and clear on accept or withdraw.
  always_ff @(posedge clk) begin
    for (int unsigned i = 1; i < NREQ; i++) begin
      if (!rst || !req_valid[i] || req_ready[i]) begin
        wait_cnt[i] <= '0;
      end else if (wait_cnt[i] != 8'hFF) begin
        wait_cnt[i] <= wait_cnt[i] + 8'd1;
      end
    end
  end

  // Registered write port: address/data hold when idle; rd==0 never writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (xfer) begin
      wb_we   <= (sel_rd != 5'd0);
      wb_addr <= sel_rd;
      wb_data <= sel_data;
    end else begin
      wb_we   <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Flag reads that hit the write currently on the port.
  always_comb begin
    byp_hit1 = wb_we & (wb_addr == byp_ra1) & (byp_ra1 != 5'd0);
    byp_hit2 = wb_we & (wb_addr == byp_ra2) & (byp_ra2 != 5'd0);
    byp_data = wb_data;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter. It runs two instances on shared stimulus:
// u_rr (all round-robin) and u_pri (requester 0 priority with the starvation guard).
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int MW = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  valid;
  logic [14:0] rd;
  logic [95:0] data;

  logic [2:0]  rr_ready, pri_ready;
  logic        rr_we, pri_we, rr_stall, pri_stall;
  logic [4:0]  rr_addr, pri_addr;
  logic [31:0] rr_data, pri_data;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_ra1, byp_ra2;
  logic        rr_hit1, rr_hit2, pri_hit1, pri_hit2;
  logic [31:0] rr_bdata, pri_bdata;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state: index 0 models u_rr, index 1 models u_pri
  int          m_ptr [2];
  int          m_wait[2][3];
  logic        m_we  [2];
  logic [4:0]  m_addr[2];
  logic [31:0] m_data[2];
  int          m_g   [2];

  regfile_wb_arbiter #(.NREQ(N), .PRIO0(0), .MAX_WAIT(MW)) u_rr (
    .clk(clk), .rst(rst), .req_valid(valid), .req_rd(rd), .req_data(data),
    .req_ready(rr_ready), .wb_we(rr_we), .wb_addr(rr_addr), .wb_data(rr_data),
`ifdef WB_BYPASS_EN
    .byp_ra1(byp_ra1), .byp_ra2(byp_ra2), .byp_hit1(rr_hit1), .byp_hit2(rr_hit2),
    .byp_data(rr_bdata),
`endif
    .pipe_stall(rr_stall)
  );

  regfile_wb_arbiter #(.NREQ(N), .PRIO0(1), .MAX_WAIT(MW)) u_pri (
    .clk(clk), .rst(rst), .req_valid(valid), .req_rd(rd), .req_data(data),
    .req_ready(pri_ready), .wb_we(pri_we), .wb_addr(pri_addr), .wb_data(pri_data),
`ifdef WB_BYPASS_EN
    .byp_ra1(byp_ra1), .byp_ra2(byp_ra2), .byp_hit1(pri_hit1), .byp_hit2(pri_hit2),
    .byp_data(pri_bdata),
`endif
    .pipe_stall(pri_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Arbitration rules: who wins this cycle, or -1 for no winner.
  function automatic int model_grant(input int d);
    bit guard;
    int i;
    if (rst !== 1'b1) return -1;
    if (d == 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr[0] + k) % N;
        if (valid[i]) return i;
      end
      return -1;
    end
    guard = 1'b0;
    for (int j = 1; j < N; j++) if (m_wait[1][j] >= MW) guard = 1'b1;
    if (valid[0] && !guard) return 0;
    for (int k = 0; k < N - 1; k++) begin
      i = 1 + (m_ptr[1] - 1 + k) % (N - 1);
      if (valid[i]) return i;
    end
    return -1;
  endfunction

  // Mid-cycle: compute the model winners and compare ready/stall.
  task automatic mid();
    logic [2:0] er;
    #3;
    for (int d = 0; d < 2; d++) begin
      m_g[d] = model_grant(d);
      er = 3'b000;
      if (m_g[d] >= 0) er[m_g[d]] = 1'b1;
      chk($sformatf("ready%0d", d), 32'(d == 0 ? rr_ready : pri_ready), 32'(er));
      chk($sformatf("stall%0d", d), 32'(d == 0 ? rr_stall : pri_stall),
          32'(valid[0] & ~er[0]));
    end
  endtask

  // Clock edge: advance the model, then compare the registered write port.
  task automatic edge_();
    int g;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      g = m_g[d];
      if (rst !== 1'b1) begin
        m_ptr[d] = d;
        m_we[d] = 1'b0; m_addr[d] = '0; m_data[d] = '0;
        for (int i = 0; i < N; i++) m_wait[d][i] = 0;
      end else begin
        if (g >= 0) begin
          m_addr[d] = rd[5*g +: 5];
          m_data[d] = data[32*g +: 32];
          m_we[d]   = (m_addr[d] != 5'd0);
          if (d == 0) m_ptr[0] = (g + 1) % N;
          else if (g >= 1) m_ptr[1] = (g == N - 1) ? 1 : g + 1;
        end else begin
          m_we[d] = 1'b0;
        end
        for (int i = 1; i < N; i++) begin
          if (!valid[i] || g == i) m_wait[d][i] = 0;
          else if (m_wait[d][i] < 255) m_wait[d][i]++;
        end
      end
    end
    #1;
    chk("we0",   32'(rr_we),   32'(m_we[0]));
    chk("addr0", 32'(rr_addr), 32'(m_addr[0]));
    chk("data0", rr_data,      m_data[0]);
    chk("we1",   32'(pri_we),  32'(m_we[1]));
    chk("addr1", 32'(pri_addr), 32'(m_addr[1]));
    chk("data1", pri_data,     m_data[1]);
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [14:0] rd;
    logic [95:0] data;
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } vec_t;

  localparam logic [14:0] RD567 = {5'd7, 5'd6, 5'd5};
  localparam logic [31:0] DA = 32'hAAAA_0000;
  localparam logic [31:0] DB = 32'hBBBB_0001;
  localparam logic [31:0] DC = 32'hCCCC_0002;

  initial begin
    vec_t tbl[12];
    logic [95:0] dabc;
    dabc = {DC, DB, DA};
    tbl[0]  = '{1'b0, 3'b111, RD567, dabc, 3'b000, 1'b0, 5'd0, 32'h0};
    tbl[1]  = '{1'b0, 3'b111, RD567, dabc, 3'b000, 1'b0, 5'd0, 32'h0};
    tbl[2]  = '{1'b1, 3'b111, RD567, dabc, 3'b001, 1'b1, 5'd5, DA};
    tbl[3]  = '{1'b1, 3'b111, RD567, dabc, 3'b010, 1'b1, 5'd6, DB};
    tbl[4]  = '{1'b1, 3'b111, RD567, dabc, 3'b100, 1'b1, 5'd7, DC};
    tbl[5]  = '{1'b1, 3'b111, RD567, dabc, 3'b001, 1'b1, 5'd5, DA};
    tbl[6]  = '{1'b1, 3'b110, RD567, dabc, 3'b010, 1'b1, 5'd6, DB};
    tbl[7]  = '{1'b1, 3'b011, RD567, dabc, 3'b001, 1'b1, 5'd5, DA};
    tbl[8]  = '{1'b1, 3'b000, RD567, dabc, 3'b000, 1'b0, 5'd5, DA};
    tbl[9]  = '{1'b1, 3'b101, RD567, dabc, 3'b100, 1'b1, 5'd7, DC};
    tbl[10] = '{1'b1, 3'b100, {5'd0, 5'd6, 5'd5}, {32'hFFFF_FFFF, DB, DA},
                3'b100, 1'b0, 5'd0, 32'hFFFF_FFFF};
    tbl[11] = '{1'b1, 3'b001, RD567, dabc, 3'b001, 1'b1, 5'd5, DA};

`ifdef WB_BYPASS_EN
    byp_ra1 = '0;
    byp_ra2 = '0;
`endif

    // Table: reset, then the round-robin rotation on u_rr
    for (int v = 0; v < 12; v++) begin
      rst = tbl[v].rst; valid = tbl[v].valid; rd = tbl[v].rd; data = tbl[v].data;
      mid();
      chk($sformatf("tbl%0d_ready", v), 32'(rr_ready), 32'(tbl[v].ready));
      edge_();
      chk($sformatf("tbl%0d_we", v),   32'(rr_we),   32'(tbl[v].we));
      chk($sformatf("tbl%0d_addr", v), 32'(rr_addr), 32'(tbl[v].addr));
      chk($sformatf("tbl%0d_data", v), rr_data,      tbl[v].wdata);
    end

    // Starvation guard on u_pri: requester 1 gets in on the fifth cycle
    rst = 1'b0; valid = 3'b000;
    mid(); edge_();
    rst = 1'b1; valid = 3'b011;
    rd = {5'd0, 5'd9, 5'd1}; data = {32'h0, 32'hDEAD_BEEF, 32'h0000_1111};
    for (int c = 0; c < 5; c++) begin
      mid();
      chk($sformatf("starve%0d_ready", c), 32'(pri_ready), (c < 4) ? 32'd1 : 32'd2);
      chk($sformatf("starve%0d_stall", c), 32'(pri_stall), (c == 4) ? 32'd1 : 32'd0);
      edge_();
      if (c == 4) begin
        chk("starve_we",   32'(pri_we),   32'd1);
        chk("starve_addr", 32'(pri_addr), 32'd9);
        chk("starve_data", pri_data,      32'hDEAD_BEEF);
      end
    end
    valid = 3'b001;
    mid();
    chk("after_guard_ready", 32'(pri_ready), 32'd1);
    chk("after_guard_stall", 32'(pri_stall), 32'd0);
    edge_();

    // Reset right after a grant discards the pending write
    rst = 1'b0; valid = 3'b000;
    mid(); edge_();
    rst = 1'b1; valid = 3'b010; rd = {5'd0, 5'd3, 5'd0}; data = {32'h0, 32'h12, 32'h0};
    mid();
    chk("rstgrant_ready", 32'(pri_ready), 32'd2);
    edge_();
    chk("rstgrant_we", 32'(pri_we), 32'd1);
    chk("rstgrant_addr", 32'(pri_addr), 32'd3);
    rst = 1'b0;
    mid();
    chk("rstmid_ready", 32'(pri_ready), 32'd0);
    edge_();
    chk("rstmid_we", 32'(pri_we), 32'd0);
    chk("rstmid_addr", 32'(pri_addr), 32'd0);
    rst = 1'b1;
    mid();
    chk("rerun_ready", 32'(pri_ready), 32'd2);
    edge_();
    chk("rerun_we", 32'(pri_we), 32'd1);
    chk("rerun_addr", 32'(pri_addr), 32'd3);
    chk("rerun_data", pri_data, 32'h12);

`ifdef WB_BYPASS_EN
    // Bypass compare against the pending write
    valid = 3'b010; rd = {5'd0, 5'd4, 5'd0}; data = {32'h0, 32'h55, 32'h0};
    byp_ra1 = 5'd4; byp_ra2 = 5'd0;
    mid(); edge_();
    chk("byp_hit1", 32'(pri_hit1), 32'd1);
    chk("byp_hit2", 32'(pri_hit2), 32'd0);
    chk("byp_data", pri_bdata, 32'h55);
    valid = 3'b000; byp_ra2 = 5'd4;
    #1;
    chk("byp_hit2_b", 32'(pri_hit2), 32'd1);
    mid(); edge_();
    chk("byp_idle_hit1", 32'(pri_hit1), 32'd0);
`endif

    // Random traffic against the model; payload is held while a request is pending on u_pri
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 29) != 0);
      for (int i = 0; i < N; i++) begin
        if (!(valid[i] && m_g[1] != i && $urandom_range(0, 7) != 0)) begin
          valid[i] = 1'($urandom_range(0, 1));
          rd[5*i +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
          data[32*i +: 32] = $urandom;
        end
      end
      mid();
      edge_();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
